// File: rtl/pc_unit_pkg.sv
// Shared encodings and default addresses for the fetch-PC generator.
package pc_unit_pkg;

  localparam logic [2:0] NPC_SEQ      = 3'd0;
  localparam logic [2:0] NPC_BRANCH   = 3'd1;
  localparam logic [2:0] NPC_JUMP_IMM = 3'd2;
  localparam logic [2:0] NPC_JUMP_REG = 3'd3;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_npc_target_calc.sv
// Combinational D-stage redirect decision and target address.
module npc_target_calc
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              stall,
  input  logic [2:0]        npc_sel,
  input  logic              cmp_true,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] jump_reg,
  output logic              d_redir,
  output logic [ADDR_W-1:0] d_target
);

  logic [ADDR_W-1:0] br_off;

  always_comb begin
    br_off   = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
    d_redir  = 1'b0;
    d_target = d_pc + ADDR_W'(4);
    case (npc_sel)
      NPC_SEQ: d_redir = 1'b0;
      NPC_BRANCH: begin
        d_redir  = cmp_true;
        d_target = d_pc + ADDR_W'(4) + br_off;
      end
      NPC_JUMP_IMM: begin
        d_redir        = 1'b1;
        // Upper region bits come from the D-stage PC.
        d_target       = d_pc;
        d_target[27:0] = {imm26, 2'b00};
      end
      NPC_JUMP_REG: begin
        d_redir  = 1'b1;
        d_target = jump_reg;
      end
      default: d_redir = 1'b0;
    endcase
    if (stall) d_redir = 1'b0;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-PC register with redirect priority, one-entry pending redirect and fetch fault flag.
// Optional PC_PERF_EN adds saturating redirect/stall counters.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
  parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] IMEM_SIZE  = ADDR_W'(32'h0000_4000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [25:0]       imm26,
  input  logic [2:0]        npc_sel,
  input  logic              cmp_true,
  input  logic [ADDR_W-1:0] jump_reg,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_exc_adel,
`ifdef PC_PERF_EN
  output logic [31:0]       redirect_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              redirect_pending
);

  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pending_target_q, pending_target_d;
  logic              d_redir;
  logic [ADDR_W-1:0] d_target;
  logic              advance;
  logic              redir_applied;
  logic [ADDR_W:0]   win_end;

  npc_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .stall    (stall),
    .npc_sel  (npc_sel),
    .cmp_true (cmp_true),
    .d_pc     (d_pc),
    .imm26    (imm26),
    .jump_reg (jump_reg),
    .d_redir  (d_redir),
    .d_target (d_target)
  );

  always_comb begin
    advance          = imem_ready && !stall;
    f_pc_d           = f_pc_q;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    redir_applied    = 1'b0;
    if (req) begin
      f_pc_d        = EXC_VECTOR;
      pending_d     = 1'b0;
      redir_applied = 1'b1;
    end else if (eret) begin
      f_pc_d        = epc;
      pending_d     = 1'b0;
      redir_applied = 1'b1;
    end else if (advance && pending_q) begin
      // The older latched redirect beats whatever D presents now.
      f_pc_d        = pending_target_q;
      pending_d     = 1'b0;
      redir_applied = 1'b1;
    end else if (advance && d_redir) begin
      f_pc_d        = d_target;
      redir_applied = 1'b1;
    end else if (advance) begin
      f_pc_d = f_pc_q + ADDR_W'(4);
    end else if (d_redir && !pending_q) begin
      pending_d        = 1'b1;
      pending_target_d = d_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q           <= RESET_PC;
      pending_q        <= 1'b0;
      pending_target_q <= '0;
    end else begin
      f_pc_q           <= f_pc_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
    end
  end

`ifdef PC_PERF_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (redir_applied && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + 32'd1;
    if (!advance && !req && !eret && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = redir_applied;
`endif

  // Window end computed one bit wider so a window touching 2^ADDR_W cannot wrap.
  assign win_end          = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
  assign f_exc_adel       = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_BASE)
                            || ({1'b0, f_pc_q} >= win_end);
  assign f_pc             = f_pc_q;
  assign redirect_pending = pending_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default build; PC_PERF_EN adds counter checks).
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, req, eret, cmp_true;
  logic [31:0] epc, d_pc, jump_reg;
  logic [25:0] imm26;
  logic [2:0]  npc_sel;
  logic [31:0] f_pc;
  logic        f_exc_adel, redirect_pending;
`ifdef PC_PERF_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .req(req), .eret(eret), .epc(epc), .d_pc(d_pc), .imm26(imm26),
    .npc_sel(npc_sel), .cmp_true(cmp_true), .jump_reg(jump_reg),
    .f_pc(f_pc), .f_exc_adel(f_exc_adel),
`ifdef PC_PERF_EN
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt),
`endif
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; imem_ready = 0; req = 0; eret = 0; cmp_true = 0;
    epc = 0; d_pc = 0; jump_reg = 0; imm26 = 0; npc_sel = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; imem_ready = 1; npc_sel = 3'd3; jump_reg = 32'h0000_5000; req = 1;
    tick();
    reset = 0; req = 0; npc_sel = 0;
    total++; if (f_pc !== 32'h3000) $display("FAIL reset_pc: got %h expected %h", f_pc, 32'h3000); else passed++;
    total++; if (redirect_pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", redirect_pending); else passed++;
    total++; if (f_exc_adel !== 1'b0) $display("FAIL reset_adel: got %b expected 0", f_exc_adel); else passed++;
`ifdef PC_PERF_EN
    total++; if (redirect_cnt !== 32'd0) $display("FAIL reset_redir_cnt: got %0d expected 0", redirect_cnt); else passed++;
`endif
    tick();
    total++; if (f_pc !== 32'h3004) $display("FAIL seq_1: got %h expected %h", f_pc, 32'h3004); else passed++;
    tick();
    total++; if (f_pc !== 32'h3008) $display("FAIL seq_2: got %h expected %h", f_pc, 32'h3008); else passed++;
  endtask

  task automatic test_branch();
    imem_ready = 1; d_pc = 32'h3010; npc_sel = 3'd1; cmp_true = 1; imm26 = 26'h000FFFC;
    tick();
    total++; if (f_pc !== 32'h3004) $display("FAIL branch_back: got %h expected %h", f_pc, 32'h3004); else passed++;
    cmp_true = 0;
    tick();
    total++; if (f_pc !== 32'h3008) $display("FAIL branch_not_taken: got %h expected %h", f_pc, 32'h3008); else passed++;
    cmp_true = 1; imm26 = 26'h3FF0010;
    tick();
    total++; if (f_pc !== 32'h3054) $display("FAIL branch_fwd: got %h expected %h", f_pc, 32'h3054); else passed++;
    npc_sel = 0; cmp_true = 0;
  endtask

  task automatic test_pending();
    imem_ready = 0; npc_sel = 3'd2; imm26 = 26'h0000C40; d_pc = 32'h3000;
    tick();
    total++; if (f_pc !== 32'h3054) $display("FAIL pend_hold: got %h expected %h", f_pc, 32'h3054); else passed++;
    total++; if (redirect_pending !== 1'b1) $display("FAIL pend_set: got %b expected 1", redirect_pending); else passed++;
    npc_sel = 3'd3; jump_reg = 32'h3200;
    tick();
    total++; if (f_pc !== 32'h3054) $display("FAIL pend_second_drop: got %h expected %h", f_pc, 32'h3054); else passed++;
    imem_ready = 1;
    tick();
    total++; if (f_pc !== 32'h3100) $display("FAIL pend_apply: got %h expected %h", f_pc, 32'h3100); else passed++;
    total++; if (redirect_pending !== 1'b0) $display("FAIL pend_clear: got %b expected 0", redirect_pending); else passed++;
    npc_sel = 0;
    tick();
    total++; if (f_pc !== 32'h3104) $display("FAIL pend_after_seq: got %h expected %h", f_pc, 32'h3104); else passed++;
  endtask

  task automatic test_exc_priority();
    imem_ready = 0; npc_sel = 3'd3; jump_reg = 32'h3300;
    tick();
    total++; if (redirect_pending !== 1'b1) $display("FAIL exc_pre_pending: got %b expected 1", redirect_pending); else passed++;
    npc_sel = 0; stall = 1; req = 1; eret = 1; epc = 32'h3020;
    tick();
    total++; if (f_pc !== 32'h4180) $display("FAIL exc_vector: got %h expected %h", f_pc, 32'h4180); else passed++;
    total++; if (redirect_pending !== 1'b0) $display("FAIL exc_pending_clr: got %b expected 0", redirect_pending); else passed++;
    total++; if (f_exc_adel !== 1'b0) $display("FAIL exc_adel: got %b expected 0", f_exc_adel); else passed++;
    stall = 0; req = 0; eret = 0;
  endtask

  task automatic test_eret_adel();
    epc = 32'h3020; eret = 1;
    tick();
    total++; if (f_pc !== 32'h3020) $display("FAIL eret_pc: got %h expected %h", f_pc, 32'h3020); else passed++;
    eret = 0; imem_ready = 1; npc_sel = 3'd3; jump_reg = 32'h3002;
    tick();
    total++; if (f_pc !== 32'h3002) $display("FAIL jr_misalign_pc: got %h expected %h", f_pc, 32'h3002); else passed++;
    total++; if (f_exc_adel !== 1'b1) $display("FAIL adel_misalign: got %b expected 1", f_exc_adel); else passed++;
    jump_reg = 32'h7000;
    tick();
    total++; if (f_exc_adel !== 1'b1) $display("FAIL adel_top: got %b expected 1", f_exc_adel); else passed++;
    jump_reg = 32'h6FFC;
    tick();
    total++; if (f_exc_adel !== 1'b0) $display("FAIL adel_last_word: got %b expected 0", f_exc_adel); else passed++;
    jump_reg = 32'h2FFC;
    tick();
    total++; if (f_exc_adel !== 1'b1) $display("FAIL adel_below: got %b expected 1", f_exc_adel); else passed++;
    jump_reg = 32'hFFFF_FFFC;
    tick();
    npc_sel = 0;
    tick();
    total++; if (f_pc !== 32'h0) $display("FAIL seq_wrap: got %h expected %h", f_pc, 32'h0); else passed++;
  endtask

  task automatic test_stall();
    imem_ready = 1; npc_sel = 3'd3; jump_reg = 32'h3010;
    tick();
    stall = 1; imem_ready = 0; jump_reg = 32'h3040;
    tick();
    total++; if (f_pc !== 32'h3010) $display("FAIL stall_hold: got %h expected %h", f_pc, 32'h3010); else passed++;
    total++; if (redirect_pending !== 1'b0) $display("FAIL stall_no_latch: got %b expected 0", redirect_pending); else passed++;
    imem_ready = 1;
    tick();
    total++; if (f_pc !== 32'h3010) $display("FAIL stall_ready_hold: got %h expected %h", f_pc, 32'h3010); else passed++;
    stall = 0; imem_ready = 0;
    tick();
    total++; if (redirect_pending !== 1'b1) $display("FAIL unstall_latch: got %b expected 1", redirect_pending); else passed++;
    reset = 1;
    tick();
    reset = 0; npc_sel = 0;
    total++; if (f_pc !== 32'h3000) $display("FAIL mid_reset_pc: got %h expected %h", f_pc, 32'h3000); else passed++;
    total++; if (redirect_pending !== 1'b0) $display("FAIL mid_reset_pending: got %b expected 0", redirect_pending); else passed++;
    imem_ready = 1;
    tick();
    total++; if (f_pc !== 32'h3004) $display("FAIL post_reset_seq: got %h expected %h", f_pc, 32'h3004); else passed++;
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_branch();
    test_pending();
    test_exc_priority();
    test_eret_adel();
    test_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
